adc_captura_serial: RTL and testbench

Serial ADC front end that feeds the biquad filter stage. Once per sample period it runs a 16-clock SPI read of a 12-bit offset-binary ADC (4 leading zeros, then 12 data bits, MSB first). It converts the code to signed fixed point in the filter's Width/Presicion format and presents it on `uk` with a one-cycle `muestra_lista` strobe. The strobe drives the filter's `enable`.

---
 rtl/adc_captura_serial_if.sv | 30 +++
 rtl/adc_captura_serial.sv | 127 ++++++++++++
 tb/tb_adc_captura_serial.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_captura_serial_if.sv
// Bus between the serial ADC front end and its surroundings: SPI pins
// towards the converter plus the sample/strobe/error outputs towards the filter.
interface adc_captura_serial_if #(
  parameter int Width = 25
) ();
  logic             sdata;
  logic             cs_n;
  logic             sclk;
  logic [Width-1:0] uk;
  logic             muestra_lista;
  logic             error_trama;

  modport master (
    input  sdata,
    output cs_n,
    output sclk,
    output uk,
    output muestra_lista,
    output error_trama
  );

  modport slave (
    output sdata,
    input  cs_n,
    input  sclk,
    input  uk,
    input  muestra_lista,
    input  error_trama
  );
endinterface

// File: rtl/adc_captura_serial.sv
// Serial 12-bit offset-binary ADC reader: one 16-clock SPI frame per sample
// period, converted to signed Q(Width-Presicion-1).Presicion for the biquad.
//
// state   | meaning
// REPOSO  | cs_n=1, sclk=1, waiting for the sample-period start tick
// CAPTURA | cs_n=0, 16 sclk periods, sdata shifted in on each sclk 0->1
// ENTREGA | one cycle: cs_n=1, muestra_lista=1, uk updated unless frame error
module adc_captura_serial #(
  parameter int Width         = 25,
  parameter int Presicion     = 16,
  parameter int DivSCLK       = 4,
  parameter int CiclosMuestra = 2268
) (
  input  logic                 clock,
  input  logic                 reset,
  adc_captura_serial_if.master bus
);

  localparam int CntW = $clog2(CiclosMuestra);
  localparam int DivW = (DivSCLK > 1) ? $clog2(DivSCLK) : 1;
  localparam int Desp = Presicion - 11;
  localparam logic [CntW-1:0] PeriodoFin = CntW'(CiclosMuestra - 1);
  localparam logic [DivW-1:0] DivFin     = DivW'(DivSCLK - 1);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CAPTURA = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  estado_t          estado_q;
  logic [CntW-1:0]  periodo_q;
  logic             tick_q;
  logic [DivW-1:0]  div_q;
  logic [3:0]       bit_q;
  logic [15:0]      trama_q;
  logic             cs_n_q;
  logic             sclk_q;
  logic [Width-1:0] uk_q;
  logic             lista_q;
  logic             error_q;

  logic [11:0]      codigo_d;
  logic [Width-1:0] uk_d;
  logic             error_d;

  // Free-running sample-period counter; the registered tick marks its terminal value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      periodo_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      tick_q    <= (periodo_q == PeriodoFin);
      periodo_q <= (periodo_q == PeriodoFin) ? '0 : periodo_q + CntW'(1);
    end
  end

  // Offset binary to two's complement is an MSB flip; then scale to the filter's fraction.
  always_comb begin
    codigo_d = trama_q[11:0];
    uk_d     = {{(Width-12){~codigo_d[11]}}, ~codigo_d[11], codigo_d[10:0]} << Desp;
    error_d  = |trama_q[15:12];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= REPOSO;
      div_q    <= '0;
      bit_q    <= '0;
      trama_q  <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b1;
      uk_q     <= '0;
      lista_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      lista_q <= 1'b0;
      case (estado_q)
        REPOSO: begin
          if (tick_q) begin
            estado_q <= CAPTURA;
            cs_n_q   <= 1'b0;
            sclk_q   <= 1'b0;
            div_q    <= DivFin;
            bit_q    <= '0;
          end
        end
        CAPTURA: begin
          if (div_q != '0) begin
            div_q <= div_q - DivW'(1);
          end else if (!sclk_q) begin
            sclk_q  <= 1'b1;
            trama_q <= {trama_q[14:0], bus.sdata};
            div_q   <= DivFin;
          end else if (bit_q == 4'd15) begin
            estado_q <= ENTREGA;
            cs_n_q   <= 1'b1;
            lista_q  <= 1'b1;
            // A corrupt frame still strobes so the filter rate never slips.
            if (error_d) begin
              error_q <= 1'b1;
            end else begin
              uk_q <= uk_d;
            end
          end else begin
            sclk_q <= 1'b0;
            bit_q  <= bit_q + 4'd1;
            div_q  <= DivFin;
          end
        end
        ENTREGA: begin
          estado_q <= REPOSO;
        end
        default: begin
          estado_q <= REPOSO;
        end
      endcase
    end
  end

  assign bus.cs_n          = cs_n_q;
  assign bus.sclk          = sclk_q;
  assign bus.uk            = uk_q;
  assign bus.muestra_lista = lista_q;
  assign bus.error_trama   = error_q;

endmodule

// File: tb/tb_adc_captura_serial.sv
// Bench for adc_captura_serial: default instance plus a DivSCLK=1 /
// CiclosMuestra=40 instance, each fed by a behavioural serial ADC.
module tb_adc_captura_serial;

  localparam int P = 16;

  logic clock = 1'b0;
  logic rst_a, rst_b;
  always #5 clock = ~clock;

  adc_captura_serial_if #(.Width(25)) bus_a ();
  adc_captura_serial_if #(.Width(25)) bus_b ();

  adc_captura_serial #(.Width(25), .Presicion(16), .DivSCLK(4), .CiclosMuestra(2268)) dut_a (
    .clock (clock),
    .reset (rst_a),
    .bus   (bus_a)
  );

  adc_captura_serial #(.Width(25), .Presicion(16), .DivSCLK(1), .CiclosMuestra(40)) dut_b (
    .clock (clock),
    .reset (rst_b),
    .bus   (bus_b)
  );

  // Serial ADC models: word latched at cs_n fall, next bit presented just after each sclk fall.
  logic [15:0] palabra_a, actual_a, palabra_b, actual_b;
  logic        modelo_a, modelo_b, ruido, ruido_en;
  int          idx_a = 0, idx_b = 0;

  assign bus_a.sdata = ruido_en ? ruido : modelo_a;
  assign bus_b.sdata = modelo_b;

  always @(negedge bus_a.cs_n) begin actual_a = palabra_a; idx_a = 0; end
  always @(negedge bus_a.sclk) begin
    #1;
    if (bus_a.cs_n === 1'b0 && idx_a < 16) begin modelo_a = actual_a[15-idx_a]; idx_a++; end
  end
  always @(negedge bus_b.cs_n) begin actual_b = palabra_b; idx_b = 0; end
  always @(negedge bus_b.sclk) begin
    #1;
    if (bus_b.cs_n === 1'b0 && idx_b < 16) begin modelo_b = actual_b[15-idx_b]; idx_b++; end
  end

  logic        sel;
  logic        mon_cs, mon_sclk, mon_lista, mon_err;
  logic [24:0] mon_uk;
  assign mon_cs    = sel ? bus_b.cs_n          : bus_a.cs_n;
  assign mon_sclk  = sel ? bus_b.sclk          : bus_a.sclk;
  assign mon_lista = sel ? bus_b.muestra_lista : bus_a.muestra_lista;
  assign mon_err   = sel ? bus_b.error_trama   : bus_a.error_trama;
  assign mon_uk    = sel ? bus_b.uk            : bus_a.uk;

  int ciclo_n = 0;
  always @(posedge clock) ciclo_n <= ciclo_n + 1;

  int n_cmp = 0, n_err = 0;
  int t_cs, t_strobe, t_rel, strobes_wait;
  logic [24:0] uk_ref;
  logic        err_ref;

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: c - 2048 scaled by 2^(P-11), wrapped to 25 bits.
  function automatic logic [24:0] conv(input logic [11:0] c);
    int v;
    v = (int'(c) - 2048) * (1 << (P - 11));
    return v[24:0];
  endfunction

  task automatic ref_frame(input logic [15:0] w);
    if (w[15:12] != 4'h0) err_ref = 1'b1;
    else uk_ref = conv(w[11:0]);
  endtask

  task automatic mide_trama(input int D, input int C, input bit chk_per,
                            input logic [24:0] exp_uk, input logic exp_err, input string tag);
    int   t, n, subidas, malos;
    logic prev;
    t = 0;
    strobes_wait = 0;
    while (mon_cs !== 1'b0 && t < C + 4) begin
      if (mon_lista === 1'b1) strobes_wait++;
      ciclo();
      t++;
    end
    chk({tag, "/cs_fall"}, 64'(mon_cs), 64'd0);
    chk({tag, "/no_extra_strobe"}, 64'(strobes_wait), 64'd0);
    t_cs = ciclo_n;
    n = 0; subidas = 0; malos = 0; prev = 1'b1;
    while (mon_cs === 1'b0 && n < 40 * D) begin
      if (mon_sclk !== (((n / D) % 2) == 1)) malos++;
      if (mon_sclk === 1'b1 && prev === 1'b0) subidas++;
      prev = mon_sclk;
      ciclo();
      n++;
    end
    chk({tag, "/cs_low"}, 64'(n), 64'(32 * D));
    chk({tag, "/sclk_rises"}, 64'(subidas), 64'd16);
    chk({tag, "/sclk_phase"}, 64'(malos), 64'd0);
    chk({tag, "/strobe"}, 64'(mon_lista), 64'd1);
    chk({tag, "/uk"}, 64'(mon_uk), 64'(exp_uk));
    chk({tag, "/err"}, 64'(mon_err), 64'(exp_err));
    if (chk_per) chk({tag, "/period"}, 64'(ciclo_n - t_strobe), 64'(C));
    t_strobe = ciclo_n;
    ciclo();
    chk({tag, "/strobe_width"}, 64'(mon_lista), 64'd0);
  endtask

  logic [11:0] cod_tab [5] = '{12'h800, 12'hFFF, 12'h000, 12'h801, 12'h7FF};
  logic [24:0] uk_tab  [5] = '{25'h0000000, 25'h000FFE0, 25'h1FF0000, 25'h0000020, 25'h1FFFFE0};

  initial begin
    logic [11:0] cod;
    int          t;
    sel = 1'b0; ruido_en = 1'b1; ruido = 1'b0;
    palabra_a = 16'h0000; palabra_b = 16'h0000;
    rst_a = 1'b1; rst_b = 1'b1;
    #2;
    rst_a = 1'b0; rst_b = 1'b0;
    uk_ref = '0; err_ref = 1'b0;

    for (int i = 0; i < 20; i++) begin
      ruido = 1'($urandom_range(0, 1));
      ciclo();
      chk("reset_hold", {mon_cs, mon_sclk, mon_lista, mon_err, mon_uk}, {4'b1100, 25'h0});
    end

    ruido_en = 1'b0;
    rst_a = 1'b1;
    t_rel = ciclo_n;
    for (int i = 0; i < 5; i++) begin
      palabra_a = {4'h0, cod_tab[i]};
      ref_frame(palabra_a);
      mide_trama(4, 2268, i > 0, uk_tab[i], 1'b0, $sformatf("map%0d", i));
      if (i == 0) chk("first_frame_delay", 64'(t_cs - t_rel), 64'd2269);
    end

    for (int i = 0; i < 3; i++) begin
      cod = 12'($urandom_range(0, 4095));
      palabra_a = {4'h0, cod};
      ref_frame(palabra_a);
      mide_trama(4, 2268, 1'b1, uk_ref, err_ref, $sformatf("rnd%0d", i));
    end

    palabra_a = 16'h0FFF;
    ref_frame(palabra_a);
    mide_trama(4, 2268, 1'b1, uk_ref, err_ref, "pre_err");
    palabra_a = 16'h8123;
    ref_frame(palabra_a);
    mide_trama(4, 2268, 1'b1, uk_ref, err_ref, "err_bit15");
    palabra_a = {4'h0, 12'($urandom_range(0, 4095))};
    ref_frame(palabra_a);
    mide_trama(4, 2268, 1'b1, uk_ref, err_ref, "err_sticky");
    palabra_a = {4'($urandom_range(1, 15)), 12'($urandom_range(0, 4095))};
    ref_frame(palabra_a);
    mide_trama(4, 2268, 1'b1, uk_ref, err_ref, "err_rnd");

    // Abort during bit 7 (its low phase starts 14*DivSCLK cycles after cs_n falls).
    palabra_a = {4'h0, 12'($urandom_range(0, 4095))};
    t = 0;
    while (mon_cs !== 1'b0 && t < 2300) begin ciclo(); t++; end
    chk("abort/cs_fall", 64'(mon_cs), 64'd0);
    repeat (57) ciclo();
    chk("abort/in_frame", {mon_cs, mon_sclk}, 2'b00);
    #2;
    rst_a = 1'b0;
    #1;
    chk("abort/async", {mon_cs, mon_sclk, mon_lista, mon_err, mon_uk}, {4'b1100, 25'h0});
    uk_ref = '0; err_ref = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ciclo();
      chk("abort/hold", {mon_cs, mon_sclk, mon_lista, mon_err, mon_uk}, {4'b1100, 25'h0});
    end
    rst_a = 1'b1;
    t_rel = ciclo_n;
    palabra_a = {4'h0, 12'($urandom_range(0, 4095))};
    ref_frame(palabra_a);
    mide_trama(4, 2268, 1'b0, uk_ref, err_ref, "post_abort");
    chk("post_abort/delay", 64'(t_cs - t_rel), 64'd2269);

    sel = 1'b1;
    ciclo();
    rst_b = 1'b1;
    t_rel = ciclo_n;
    palabra_b = 16'h0FFF;
    mide_trama(1, 40, 1'b0, 25'h000FFE0, 1'b0, "var0");
    chk("var/first_delay", 64'(t_cs - t_rel), 64'd41);
    for (int i = 1; i < 4; i++) begin
      cod = 12'($urandom_range(0, 4095));
      palabra_b = {4'h0, cod};
      mide_trama(1, 40, 1'b1, conv(cod), 1'b0, $sformatf("var%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
